// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction width, decoder field
// positions and the fetch FSM state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 9;
  localparam int FLAG_BIT   = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;
  localparam int RA_MSB     = 7;
  localparam int RA_LSB     = 5;
  localparam int RB_MSB     = 4;
  localparam int RB_LSB     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory request path, decoder hand-off,
// and the sequencer/branch control inputs.
interface instruction_fetch_if #(parameter int ADDR_W = 16);

  logic                         fetch_en;
  logic                         mem_req;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_ready;
  logic [cpu_pkg::INSTR_W-1:0]  mem_rdata;
  logic                         branch_valid;
  logic [ADDR_W-1:0]            branch_target;
  logic [cpu_pkg::INSTR_W-1:0]  instruct;
  logic                         instr_valid;
  logic                         instr_ready;
  logic [ADDR_W-1:0]            instr_pc;
  logic [ADDR_W-1:0]            pc;

  modport master (
    input  fetch_en, mem_ready, mem_rdata, branch_valid, branch_target, instr_ready,
    output mem_req, mem_addr, instruct, instr_valid, instr_pc, pc
  );

  modport slave (
    output fetch_en, mem_ready, mem_rdata, branch_valid, branch_target, instr_ready,
    input  mem_req, mem_addr, instruct, instr_valid, instr_pc, pc
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter register: branch load takes priority over increment,
// increment wraps modulo 2^ADDR_W.
module pc_counter #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // next-PC selection
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: IDLE/REQ/HOLD sequencer issuing word reads and presenting
// the returned word to the decoder; branches redirect and squash.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  fetch_state_t        state_d, state_q;
  logic                mem_req_d, mem_req_q;
  logic                instr_valid_d, instr_valid_q;
  logic [INSTR_W-1:0]  instruct_d, instruct_q;
  logic [ADDR_W-1:0]   instr_pc_d, instr_pc_q;
  logic                pc_load_s;
  logic                pc_inc_s;
  logic [ADDR_W-1:0]   pc_s;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_load_s),
    .inc      (pc_inc_s),
    .load_val (bus.branch_target),
    .pc       (pc_s)
  );

  // next-state and output decode; branch outranks every other event
  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instruct_d    = instruct_q;
    instr_pc_d    = instr_pc_q;
    pc_load_s     = 1'b0;
    pc_inc_s      = 1'b0;
    case (state_q)
      IDLE: begin
        pc_load_s = bus.branch_valid;
        if (bus.fetch_en) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.branch_valid) begin
          pc_load_s = 1'b1;
          state_d   = REQ;
        end else if (bus.mem_ready) begin
          instruct_d    = bus.mem_rdata;
          instr_pc_d    = pc_s;
          pc_inc_s      = 1'b1;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (bus.branch_valid || bus.instr_ready) begin
          pc_load_s     = bus.branch_valid;
          instr_valid_d = 1'b0;
          if (bus.fetch_en) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        instr_valid_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
    // mem_req is a registered copy of the next-state decode
    mem_req_d = (state_d == REQ);
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instruct_q    <= {INSTR_W{1'b0}};
      instr_pc_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      instruct_q    <= instruct_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc_s;
  assign bus.pc          = pc_s;
  assign bus.instruct    = instruct_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, fetch latency, back-pressure,
// branch squash, PC wrap and reset during an active request.
module tb_instruction_fetch;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   accepts;
  int   acc0;

  instruction_fetch_if #(.ADDR_W(16)) bus ();

  instruction_fetch #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // decoder-side accept counter; a branch cycle squashes the hand-off
  always @(posedge clock) begin
    if (!reset && bus.instr_valid && bus.instr_ready && !bus.branch_valid)
      accepts <= accepts + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    accepts = 0;
    reset   = 1'b1;
    bus.fetch_en      = 1'b0;
    bus.mem_ready     = 1'b0;
    bus.mem_rdata     = 16'h0000;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.instr_ready   = 1'b0;

    // 1. reset for 3 cycles then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_pc", bus.pc, 16'h0000);
      check("rst_req", 16'(bus.mem_req), 16'h0000);
      check("rst_valid", 16'(bus.instr_valid), 16'h0000);
      check("rst_instr", bus.instruct, 16'h0000);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("idle_pc", bus.pc, 16'h0000);
      check("idle_req", 16'(bus.mem_req), 16'h0000);
      check("idle_valid", 16'(bus.instr_valid), 16'h0000);
    end

    // 2. first fetch, mem_ready two cycles after mem_req
    bus.fetch_en = 1'b1;
    tick();
    check("f1_req", 16'(bus.mem_req), 16'h0001);
    check("f1_addr", bus.mem_addr, 16'h0000);
    tick();
    check("f1_req_wait", 16'(bus.mem_req), 16'h0001);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hA5C3;
    tick();
    bus.mem_ready = 1'b0;
    check("f1_instr", bus.instruct, 16'hA5C3);
    check("f1_ipc", bus.instr_pc, 16'h0000);
    check("f1_pc", bus.pc, 16'h0001);
    check("f1_valid", 16'(bus.instr_valid), 16'h0001);
    check("f1_req_hold", 16'(bus.mem_req), 16'h0000);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("f1_valid_drop", 16'(bus.instr_valid), 16'h0000);
    check("f1_req2", 16'(bus.mem_req), 16'h0001);
    check("f1_addr2", bus.mem_addr, 16'h0001);
    check("f1_accepts", 16'(accepts), 16'h0001);

    // 3. back-pressure for 5 cycles
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_instr", bus.instruct, 16'h1234);
      check("bp_valid", 16'(bus.instr_valid), 16'h0001);
      check("bp_req", 16'(bus.mem_req), 16'h0000);
      check("bp_ipc", bus.instr_pc, 16'h0001);
    end
    acc0 = accepts;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    tick();
    check("bp_one_accept", 16'(accepts - acc0), 16'h0001);
    check("bp_pc", bus.pc, 16'h0002);

    // 4a. branch in HOLD with instr_ready in the same cycle
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_ready = 1'b0;
    check("br_hold_pre_pc", bus.pc, 16'h0003);
    acc0 = accepts;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0040;
    bus.instr_ready   = 1'b1;
    tick();
    bus.branch_valid = 1'b0;
    bus.instr_ready  = 1'b0;
    check("br_hold_valid", 16'(bus.instr_valid), 16'h0000);
    check("br_hold_req", 16'(bus.mem_req), 16'h0001);
    check("br_hold_addr", bus.mem_addr, 16'h0040);
    check("br_hold_noacc", 16'(accepts - acc0), 16'h0000);

    // 4b. branch in REQ coinciding with mem_ready
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0040;
    bus.mem_ready     = 1'b1;
    bus.mem_rdata     = 16'hDEAD;
    tick();
    bus.branch_valid = 1'b0;
    bus.mem_ready    = 1'b0;
    check("br_req_valid", 16'(bus.instr_valid), 16'h0000);
    check("br_req_pc", bus.pc, 16'h0040);
    check("br_req_req", 16'(bus.mem_req), 16'h0001);
    check("br_req_instr_kept", bus.instruct, 16'hBEEF);

    // 4c. branch in REQ without mem_ready
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0100;
    tick();
    bus.branch_valid = 1'b0;
    check("br_req_nr_pc", bus.mem_addr, 16'h0100);
    check("br_req_nr_req", 16'(bus.mem_req), 16'h0001);

    // 5. wrap from FFFF
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'hFFFF;
    tick();
    bus.branch_valid = 1'b0;
    check("wrap_pc_pre", bus.pc, 16'hFFFF);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_ready = 1'b0;
    check("wrap_ipc", bus.instr_pc, 16'hFFFF);
    check("wrap_pc", bus.pc, 16'h0000);
    check("wrap_instr", bus.instruct, 16'h7777);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;

    // 6. reset mid-REQ with mem_ready in the same cycle
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_ready   = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("r6_pre_req", 16'(bus.mem_req), 16'h0001);
    check("r6_pre_pc", bus.pc, 16'h0001);
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h2222;
    tick();
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.fetch_en  = 1'b0;
    check("r6_req", 16'(bus.mem_req), 16'h0000);
    check("r6_valid", 16'(bus.instr_valid), 16'h0000);
    check("r6_pc", bus.pc, 16'h0000);
    check("r6_instr", bus.instruct, 16'h0000);
    tick();
    check("r6_idle_req", 16'(bus.mem_req), 16'h0000);

    // branch while IDLE with fetch disabled
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0055;
    tick();
    bus.branch_valid = 1'b0;
    check("idle_br_pc", bus.pc, 16'h0055);
    check("idle_br_req", 16'(bus.mem_req), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Front-end stage that sits directly upstream of the instruction decoder. It holds the program counter and issues word reads to instruction memory over a level req/ready handshake. It captures the returned 16-bit word and presents it to the decoder with a valid/ready handshake. Taken branches redirect the PC and squash any wrong-path word already fetched.

Parameters:
ADDR_W, 16, instruction memory word-address width (PC width)
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
fetch_en  in  1  control sequencer permits new fetches
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  word address of the read; equals pc
mem_ready  in  1  mem_rdata valid this cycle; completes the request
mem_rdata  in  16  instruction word from memory
branch_valid  in  1  one-cycle redirect pulse
branch_target  in  ADDR_W  redirect address
instruct  out  16  fetched instruction word, drives decoder instruct
instr_valid  out  1  instruct holds a valid, unconsumed word
instr_ready  in  1  decoder accepts the word; decoder enable = instr_valid & instr_ready
instr_pc  out  ADDR_W  address the current instruct word was fetched from
pc  out  ADDR_W  next address to fetch

Behaviour:
- Reset, synchronous: pc=RESET_PC; state=IDLE; mem_req=0; instr_valid=0; instruct=16'h0000; instr_pc=0. Reset overrides all other inputs, including mid-request; an in-flight mem_ready in the reset cycle is ignored.
- mem_addr = pc combinationally in all states. mem_req = (state==REQ), registered state decode, no combinational path from inputs.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - fetch_en=1 -> REQ next cycle.
  - Otherwise stay in IDLE.
- REQ: mem_req=1.
  - mem_ready=1: instruct<=mem_rdata; instr_pc<=pc; pc<=pc+1 (mod 2^ADDR_W, FFFF->0000 at 16 bits); instr_valid<=1; -> HOLD.
  - mem_ready=0: hold in REQ.
  - fetch_en dropping during REQ does not abandon the request. The request completes, then the block moves to HOLD.
- HOLD: mem_req=0; instruct and instr_pc stable.
  - instr_ready=1: instr_valid<=0; -> REQ if fetch_en, else IDLE.
  - instr_ready=0: hold. This is back-pressure and no new request is issued.
- Latency: word available 1 cycle after the mem_ready cycle. Peak throughput is 1 instruction per 2 cycles (REQ, HOLD).
- Branch (branch_valid=1) has priority over every other event in all states:
  - IDLE: pc<=branch_target; stay IDLE unless fetch_en, then -> REQ.
  - REQ, mem_ready=0: pc<=branch_target; stay REQ. Memory sees the new address next cycle; memory holds no outstanding state.
  - REQ, mem_ready=1: returned word discarded; instr_valid stays 0; pc<=branch_target; stay REQ.
  - HOLD: held word squashed, instr_valid<=0. instr_ready is ignored that cycle. pc<=branch_target; -> REQ if fetch_en, else IDLE.
- instruct is not cleared on squash; only instr_valid qualifies it.
- pc increments only on a completed, non-squashed fetch.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_W=16.
  - Decoder field positions: opcode [15:12], rD [11:9], flag [8], imm [7:0], rA [7:5], rB [4:2].
  - fetch_state_t enum {IDLE, REQ, HOLD}.
- One natural sub-module, pc_counter: ADDR_W register with sync reset to RESET_PC, load (branch) and increment inputs, load over increment.

Test Plan:
1. Reset asserted 3 cycles, then released with fetch_en=0 -> pc=0000, mem_req=0, instr_valid=0, instruct=0000 for all cycles.
2. fetch_en=1, mem_ready raised 2 cycles after mem_req with mem_rdata=16'hA5C3 -> next cycle instruct=A5C3, instr_pc=0000, pc=0001, instr_valid=1; instr_ready=1 -> valid drops and mem_req reasserts with mem_addr=0001.
3. Back-pressure: word 16'h1234 held with instr_ready=0 for 5 cycles -> instruct=1234 and instr_valid=1 stable, mem_req=0 throughout; release -> exactly one accept.
4. Branch in HOLD with target 16'h0040 and instr_ready=1 in the same cycle -> instr_valid=0 next cycle, no accept counted, next mem_req has mem_addr=0040. Branch in REQ with mem_ready=1 -> word dropped, pc=0040.
5. Wrap: branch to FFFF, fetch completes -> instr_pc=FFFF, pc=0000.
6. Reset mid-REQ with mem_ready=1 in the same cycle -> next cycle mem_req=0, instr_valid=0, pc=RESET_PC, word discarded.
